// File: rtl/rule_match_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rule_match_collector_pkg
// Description : Shared types and constants for the matched-rule collector.
// Revision    : 1.0 - initial release
// ============================================================================
package rule_match_collector_pkg;

    localparam int RULE_AWIDTH         = 12;
    localparam int FIFO_AWIDTH_DEFAULT = 5;
    localparam int DEDUP_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic                   last;
        logic                   ovf;
        logic [RULE_AWIDTH-1:0] rule_id;
    } collector_entry_t;

    function automatic collector_entry_t make_entry(
        input logic                   last,
        input logic                   ovf,
        input logic [RULE_AWIDTH-1:0] rule_id
    );
        collector_entry_t e;
        e.last    = last;
        e.ovf     = ovf;
        e.rule_id = rule_id;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rule_match_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rule_fifo
// Description : Synchronous show-ahead FIFO of collector entries; the head
//               entry is visible on o_rd_data whenever o_empty is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rule_fifo
    import rule_match_collector_pkg::*;
#(
    parameter int AWIDTH = FIFO_AWIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  collector_entry_t i_wr_data,
    input  logic             i_rd_en,
    output collector_entry_t o_rd_data,
    output logic [AWIDTH:0]  o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int              c_DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] c_FULL  = (AWIDTH+1)'(c_DEPTH);

    collector_entry_t    r_mem [c_DEPTH];
    logic [AWIDTH-1:0]   r_wr_ptr;
    logic [AWIDTH-1:0]   r_rd_ptr;
    logic [AWIDTH:0]     r_count;
    logic                w_wr;
    logic                w_rd;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AWIDTH+1)'(1);
                2'b01:   r_count <= r_count - (AWIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; the consumer only looks at it when not empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/rule_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : rule_match_collector
// Description : Suppresses duplicate rule IDs per packet, queues survivors and
//               guarantees exactly one last-flagged entry per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module rule_match_collector
    import rule_match_collector_pkg::*;
#(
    parameter int FIFO_AWIDTH   = FIFO_AWIDTH_DEFAULT,
    parameter int DEDUP_DEPTH   = DEDUP_DEPTH_DEFAULT,
    parameter int EOP_CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RULE_AWIDTH-1:0] in_rule_data,
    input  logic                   in_rule_valid,
    input  logic                   in_pkt_last,
    output logic [RULE_AWIDTH-1:0] out_rule_data,
    output logic                   out_last,
    output logic                   out_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            stat_dup_cnt,
    output logic [31:0]            stat_drop_cnt
);

    localparam int                     c_DEPTH    = 1 << FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH:0]   c_RESERVE  = (FIFO_AWIDTH+1)'(c_DEPTH - 2);
    localparam logic [EOP_CNT_WIDTH-1:0] c_PEND_MAX = '1;
    localparam logic [31:0]            c_STAT_MAX = 32'hFFFF_FFFF;

    logic [RULE_AWIDTH-1:0]   r_tbl_id [DEDUP_DEPTH];
    logic [DEDUP_DEPTH-1:0]   r_tbl_vld;
    logic                     r_pkt_ovf;
    logic [EOP_CNT_WIDTH-1:0] r_pend;
    logic [31:0]              r_dup_cnt;
    logic [31:0]              r_drop_cnt;

    logic [DEDUP_DEPTH-1:0]   w_match;
    logic                     w_r;
    logic                     w_l;
    logic                     w_d;
    logic                     w_wr_en;
    collector_entry_t         w_wr_entry;
    collector_entry_t         w_rd_entry;
    logic [FIFO_AWIDTH:0]     w_cnt;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pkt_ovf_nxt;
    logic [EOP_CNT_WIDTH-1:0] w_pend_nxt;
    logic                     w_dup_inc;
    logic                     w_drop_inc;
    logic                     w_tbl_ins;
    logic [31:0]              w_dup_cnt_nxt;
    logic [31:0]              w_drop_cnt_nxt;

    for (genvar gi = 0; gi < DEDUP_DEPTH; gi++) begin : g_dedup_cmp
        assign w_match[gi] = r_tbl_vld[gi] && (r_tbl_id[gi] == in_rule_data);
    end

    assign w_r = in_rule_valid && (in_rule_data != '0);
    assign w_l = in_pkt_last;
    assign w_d = w_r && (|w_match);

    // Write arbitration: owed terminators first, then the packet close, then rules.
    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_entry    = '0;
        w_pend_nxt    = r_pend;
        w_pkt_ovf_nxt = r_pkt_ovf;
        w_dup_inc     = 1'b0;
        w_drop_inc    = 1'b0;
        w_tbl_ins     = 1'b0;
        if (r_pend != '0) begin
            if (!w_full) begin
                w_wr_en    = 1'b1;
                w_wr_entry = make_entry(1'b1, 1'b1, '0);
                if (!w_l) w_pend_nxt = r_pend - EOP_CNT_WIDTH'(1);
            end else if (w_l && (r_pend != c_PEND_MAX)) begin
                w_pend_nxt = r_pend + EOP_CNT_WIDTH'(1);
            end
            w_drop_inc = w_r;
            if (w_r && !w_l) w_pkt_ovf_nxt = 1'b1;
        end else if (w_l) begin
            if (!w_full) begin
                w_wr_en    = 1'b1;
                w_wr_entry = make_entry(1'b1, r_pkt_ovf, (w_r && !w_d) ? in_rule_data : '0);
                w_dup_inc  = w_d;
            end else begin
                w_pend_nxt = EOP_CNT_WIDTH'(1);
                w_drop_inc = w_r;
            end
        end else if (w_r && !w_d) begin
            if (w_cnt <= c_RESERVE) begin
                w_wr_en    = 1'b1;
                w_wr_entry = make_entry(1'b0, 1'b0, in_rule_data);
                w_tbl_ins  = 1'b1;
            end else begin
                w_drop_inc    = 1'b1;
                w_pkt_ovf_nxt = 1'b1;
            end
        end else if (w_d) begin
            w_dup_inc = 1'b1;
        end
        if (w_l) w_pkt_ovf_nxt = 1'b0;
    end

    always_comb begin
        w_dup_cnt_nxt  = r_dup_cnt;
        w_drop_cnt_nxt = r_drop_cnt;
        if (w_dup_inc && (r_dup_cnt != c_STAT_MAX))   w_dup_cnt_nxt  = r_dup_cnt + 32'd1;
        if (w_drop_inc && (r_drop_cnt != c_STAT_MAX)) w_drop_cnt_nxt = r_drop_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_ovf  <= 1'b0;
            r_pend     <= '0;
            r_dup_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pkt_ovf  <= w_pkt_ovf_nxt;
            r_pend     <= w_pend_nxt;
            r_dup_cnt  <= w_dup_cnt_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    // Table is a shift register: newest at index 0, oldest falls off the end.
    always_ff @(posedge clk) begin
        if (rst || w_l) begin
            r_tbl_vld <= '0;
            for (int i = 0; i < DEDUP_DEPTH; i++) r_tbl_id[i] <= '0;
        end else if (w_tbl_ins) begin
            for (int i = DEDUP_DEPTH - 1; i > 0; i--) begin
                r_tbl_id[i]  <= r_tbl_id[i-1];
                r_tbl_vld[i] <= r_tbl_vld[i-1];
            end
            r_tbl_id[0]  <= in_rule_data;
            r_tbl_vld[0] <= 1'b1;
        end
    end

    rule_fifo #(
        .AWIDTH (FIFO_AWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (out_ready),
        .o_rd_data (w_rd_entry),
        .o_count   (w_cnt),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign out_valid     = ~w_empty;
    assign out_rule_data = out_valid ? w_rd_entry.rule_id : '0;
    assign out_last      = out_valid & w_rd_entry.last;
    assign out_ovf       = out_valid & w_rd_entry.ovf;
    assign stat_dup_cnt  = r_dup_cnt;
    assign stat_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rule_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_rule_match_collector
// Description : Directed self-checking bench for rule_match_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rule_match_collector;
    import rule_match_collector_pkg::*;

    typedef logic [RULE_AWIDTH+1:0] ent_t;   // {last, ovf, rule_id}

    logic                   clk;
    logic                   rst;
    logic [RULE_AWIDTH-1:0] in_rule_data;
    logic                   in_rule_valid;
    logic                   in_pkt_last;
    logic [RULE_AWIDTH-1:0] out_rule_data;
    logic                   out_last;
    logic                   out_ovf;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            stat_dup_cnt;
    logic [31:0]            stat_drop_cnt;

    int   errors = 0;
    int   checks = 0;
    ent_t obs[$];

    rule_match_collector dut (
        .clk           (clk),
        .rst           (rst),
        .in_rule_data  (in_rule_data),
        .in_rule_valid (in_rule_valid),
        .in_pkt_last   (in_pkt_last),
        .out_rule_data (out_rule_data),
        .out_last      (out_last),
        .out_ovf       (out_ovf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .stat_dup_cnt  (stat_dup_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accepted entries, captured mid-cycle ahead of the handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs.push_back({out_last, out_ovf, out_rule_data});
    end

    function automatic ent_t mk(input logic last, input logic ovf, input int id);
        ent_t e;
        e = {last, ovf, RULE_AWIDTH'(id)};
        return e;
    endfunction

    task automatic drive(input logic v, input int id, input logic l);
        in_rule_valid = v;
        in_rule_data  = RULE_AWIDTH'(id);
        in_pkt_last   = l;
        @(posedge clk); #1;
        in_rule_valid = 1'b0;
        in_rule_data  = '0;
        in_pkt_last   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b0;
        in_rule_valid = 1'b0; in_rule_data = '0; in_pkt_last = 1'b0;
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_rule_data !== '0) begin errors++; $display("FAIL reset_data: got %0d exp 0", out_rule_data); end
        checks++; if ({out_last, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {out_last, out_ovf}); end
        checks++; if (stat_dup_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stat_dup_cnt, stat_drop_cnt); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_packet;
        ent_t exp_q[$];
        out_ready = 1'b1; obs.delete();
        drive(1, 5, 0);
        checks++; if ({out_valid, out_rule_data} !== {1'b1, RULE_AWIDTH'(5)}) begin errors++; $display("FAIL sp_lat5: got v=%b id=%0d exp v=1 id=5", out_valid, out_rule_data); end
        drive(1, 9, 0);
        checks++; if ({out_valid, out_rule_data} !== {1'b1, RULE_AWIDTH'(9)}) begin errors++; $display("FAIL sp_lat9: got v=%b id=%0d exp v=1 id=9", out_valid, out_rule_data); end
        drive(1, 5, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_dup_nowrite: got v=%b exp 0", out_valid); end
        drive(1, 12, 1);
        checks++; if ({out_valid, out_last, out_ovf, out_rule_data} !== {3'b110, RULE_AWIDTH'(12)}) begin errors++; $display("FAIL sp_last: got v=%b l=%b o=%b id=%0d exp 1 1 0 12", out_valid, out_last, out_ovf, out_rule_data); end
        idle(2);
        exp_q = '{mk(0, 0, 5), mk(0, 0, 9), mk(1, 0, 12)};
        checks++; if (obs !== exp_q) begin errors++; $display("FAIL sp_stream: got %p exp %p", obs, exp_q); end
        checks++; if (stat_dup_cnt !== 32'd1) begin errors++; $display("FAIL sp_dupcnt: got %0d exp 1", stat_dup_cnt); end
    endtask

    task automatic test_bare_terminator;
        obs.delete();
        drive(0, 0, 1);
        checks++; if ({out_valid, out_last, out_ovf, out_rule_data} !== {3'b110, RULE_AWIDTH'(0)}) begin errors++; $display("FAIL bare_term: got v=%b l=%b o=%b id=%0d exp 1 1 0 0", out_valid, out_last, out_ovf, out_rule_data); end
        idle(2);
        checks++; if (obs.size() !== 1) begin errors++; $display("FAIL bare_count: got %0d exp 1", obs.size()); end
    endtask

    task automatic test_dedup_window;
        ent_t exp_q[$];
        obs.delete();
        for (int i = 1; i <= 9; i++) begin
            drive(1, i, 0);
            exp_q.push_back(mk(0, 0, i));
        end
        drive(1, 1, 0);
        exp_q.push_back(mk(0, 0, 1));
        drive(1, 9, 0);
        drive(0, 0, 1);
        exp_q.push_back(mk(1, 0, 0));
        idle(3);
        checks++; if (obs !== exp_q) begin errors++; $display("FAIL dedup_stream: got %p exp %p", obs, exp_q); end
        checks++; if (stat_dup_cnt !== 32'd2) begin errors++; $display("FAIL dedup_dupcnt: got %0d exp 2", stat_dup_cnt); end
    endtask

    task automatic test_overflow;
        obs.delete(); out_ready = 1'b0;
        for (int i = 0; i < 40; i++) drive(1, 100 + i, 0);
        drive(0, 0, 1);
        idle(1);
        checks++; if (stat_drop_cnt !== 32'd9) begin errors++; $display("FAIL ovf_dropcnt: got %0d exp 9", stat_drop_cnt); end
        checks++; if ({out_valid, out_rule_data} !== {1'b1, RULE_AWIDTH'(100)}) begin errors++; $display("FAIL ovf_head: got v=%b id=%0d exp v=1 id=100", out_valid, out_rule_data); end
        out_ready = 1'b1;
        idle(40);
        checks++; if (obs.size() !== 32) begin errors++; $display("FAIL ovf_count: got %0d exp 32", obs.size()); end
        for (int i = 0; i < 31; i++) begin
            checks++; if (obs[i] !== mk(0, 0, 100 + i)) begin errors++; $display("FAIL ovf_rule[%0d]: got %h exp %h", i, obs[i], mk(0, 0, 100 + i)); end
        end
        checks++; if (obs[31] !== mk(1, 1, 0)) begin errors++; $display("FAIL ovf_term: got %h exp %h", obs[31], mk(1, 1, 0)); end
        drive(1, 7, 1);
        idle(2);
        checks++; if (obs.size() !== 33 || obs[32] !== mk(1, 0, 7)) begin errors++; $display("FAIL ovf_next_clean: got n=%0d %h exp n=33 %h", obs.size(), obs[obs.size()-1], mk(1, 0, 7)); end
    endtask

    task automatic test_pending_terminators;
        ent_t exp_q[$];
        obs.delete(); out_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            drive(1, 200 + i, 0);
            exp_q.push_back(mk(0, 0, 200 + i));
        end
        drive(0, 0, 1);
        exp_q.push_back(mk(1, 0, 0));
        drive(1, 300, 1);
        drive(1, 301, 0);
        drive(0, 0, 1);
        drive(1, 302, 1);
        idle(3);
        checks++; if (stat_drop_cnt !== 32'd12) begin errors++; $display("FAIL pend_dropcnt: got %0d exp 12", stat_drop_cnt); end
        checks++; if ({out_valid, out_rule_data} !== {1'b1, RULE_AWIDTH'(200)}) begin errors++; $display("FAIL pend_hold: got v=%b id=%0d exp v=1 id=200", out_valid, out_rule_data); end
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 1, 0));
        out_ready = 1'b1;
        idle(45);
        drive(1, 400, 1);
        exp_q.push_back(mk(1, 0, 400));
        idle(2);
        checks++; if (obs !== exp_q) begin errors++; $display("FAIL pend_stream: got n=%0d exp n=%0d", obs.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_packet;
        ent_t exp_q[$];
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1, 500 + i, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmp_queued: got v=%b exp 1", out_valid); end
        rst = 1'b1;
        idle(1);
        checks++; if (out_valid !== 1'b0 || out_rule_data !== '0) begin errors++; $display("FAIL rmp_valid: got v=%b id=%0d exp v=0 id=0", out_valid, out_rule_data); end
        checks++; if (stat_dup_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL rmp_stats: got %0d/%0d exp 0/0", stat_dup_cnt, stat_drop_cnt); end
        rst = 1'b0; out_ready = 1'b1;
        idle(1);
        obs.delete();
        drive(1, 509, 0);
        drive(1, 601, 1);
        idle(2);
        exp_q = '{mk(0, 0, 509), mk(1, 0, 601)};
        checks++; if (obs !== exp_q) begin errors++; $display("FAIL rmp_stream: got %p exp %p", obs, exp_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmp_drained: got v=%b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_bare_terminator();
        test_dedup_window();
        test_overflow();
        test_pending_terminators();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
